// File: rtl/freq_meas_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : freq_meas_ctrl
// Function : DDS frequency meter sequencer - gated rising-crossing counter
//            with saturating count and serial BCD conversion for the display.
// Revision : 1.0 - initial release
// ============================================================================
module freq_meas_ctrl #(
    parameter int         GATE_CYCLES = 100_000_000,
    parameter logic [7:0] THRESH      = 8'd127
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] wave,
    input  logic       start,
    input  logic       cont,
    output logic       busy,
    output logic       done,
    output logic       over,
    output logic [3:0] thou_count,
    output logic [3:0] hund_count,
    output logic [3:0] ten_count,
    output logic [3:0] one_count
);
    localparam int              c_gw        = $clog2(GATE_CYCLES);
    localparam logic [c_gw-1:0] c_gate_last = c_gw'(GATE_CYCLES - 1);
    localparam logic [13:0]     c_sat       = 14'd10000;
    localparam logic [13:0]     c_max_disp  = 14'd9999;

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_gate = 2'd1;
    localparam logic [1:0] c_st_conv = 2'd2;
    localparam logic [1:0] c_st_done = 2'd3;

    logic [1:0]      r_state;
    logic [1:0]      w_state_nxt;
    logic            r_half_d;
    logic [13:0]     r_count;
    logic [c_gw-1:0] r_gate_cnt;
    logic [3:0]      r_conv_cnt;
    logic [29:0]     r_sr;
    logic [15:0]     r_digits;
    logic            r_over;

    logic            w_half;
    logic            w_cross;
    logic            w_sat;
    logic [13:0]     w_cnt_nxt;
    logic [13:0]     w_conv_in;
    logic            w_gate_end;
    logic            w_conv_end;
    logic [29:0]     w_adj;
    logic [29:0]     w_sr_step;

    assign w_half     = (wave > THRESH);
    assign w_cross    = w_half & ~r_half_d;
    assign w_sat      = (r_count >= c_sat);
    assign w_cnt_nxt  = (w_cross && !w_sat) ? r_count + 14'd1 : r_count;
    // The conversion is loaded on the closing gate edge, so it must see the
    // crossing (if any) of that final gate cycle.
    assign w_conv_in  = (w_cnt_nxt >= c_sat) ? c_max_disp : w_cnt_nxt;
    assign w_gate_end = (r_gate_cnt == c_gate_last);
    assign w_conv_end = (r_conv_cnt == 4'd13);

    // One double-dabble step: BCD nibbles live in r_sr[29:14].
    always_comb begin
        w_adj = r_sr;
        for (int i = 0; i < 4; i++) begin
            if (w_adj[14 + 4*i +: 4] >= 4'd5)
                w_adj[14 + 4*i +: 4] = w_adj[14 + 4*i +: 4] + 4'd3;
        end
        w_sr_step = w_adj << 1;
    end

    always_ff @(posedge clk) begin
        if (rst)
            r_state <= c_st_idle;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_idle: if (start || cont) w_state_nxt = c_st_gate;
            c_st_gate: if (w_gate_end)    w_state_nxt = c_st_conv;
            c_st_conv: if (w_conv_end)    w_state_nxt = c_st_done;
            c_st_done: w_state_nxt = cont ? c_st_gate : c_st_idle;
            default:   w_state_nxt = c_st_idle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_half_d   <= 1'b0;
            r_count    <= '0;
            r_gate_cnt <= '0;
            r_conv_cnt <= '0;
            r_sr       <= '0;
            r_digits   <= '0;
            r_over     <= 1'b0;
        end else begin
            r_half_d <= w_half;
            case (r_state)
                c_st_gate: begin
                    r_count    <= w_cnt_nxt;
                    r_gate_cnt <= r_gate_cnt + c_gw'(1);
                    if (w_gate_end) begin
                        r_sr       <= {16'd0, w_conv_in};
                        r_conv_cnt <= '0;
                    end
                end
                c_st_conv: begin
                    r_sr       <= w_sr_step;
                    r_conv_cnt <= r_conv_cnt + 4'd1;
                    if (w_conv_end) begin
                        r_digits <= w_sr_step[29:14];
                        r_over   <= w_sat;
                    end
                end
                default: begin
                    // IDLE and DONE both prepare a fresh window.
                    r_count    <= '0;
                    r_gate_cnt <= '0;
                end
            endcase
        end
    end

    assign busy       = (r_state != c_st_idle);
    assign done       = (r_state == c_st_done);
    assign over       = r_over;
    assign thou_count = r_digits[15:12];
    assign hund_count = r_digits[11:8];
    assign ten_count  = r_digits[7:4];
    assign one_count  = r_digits[3:0];

endmodule
`default_nettype wire
